estagio_memoria: RTL and testbench
==================================

Name: estagio_memoria

Overview:
- Memory/IO access stage directly downstream of the combinational ALU. It consumes the ALU's alu_op, result (effective address or computed value) and saida (store data).
- Performs data-RAM loads/stores and handshaked HD (disk) transfers, stalling upstream as needed.
- For every other op it passes result through to writeback, registered.

Parameters:
- DATA_W, 32, datapath width
- MEM_AW, 10, data-RAM word-address width (result[MEM_AW-1:0] used)
- HD_TIMEOUT, 255, max cycles waiting for hd_ack before aborting

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  synchronous reset, active low
- op_valid  in  1  ALU outputs valid this cycle
- alu_op  in  6  opcode as presented to the ALU
- result  in  DATA_W  ALU result (address for lw/sw/hd ops)
- saida  in  DATA_W  ALU store-data output
- mem_addr  out  MEM_AW  data-RAM address
- mem_we  out  1  data-RAM write enable (1-cycle pulse)
- mem_wdata  out  DATA_W  data-RAM write data
- mem_rdata  in  DATA_W  data-RAM read data, valid 1 cycle after address
- hd_req  out  1  HD request, held until hd_ack or timeout
- hd_we  out  1  HD direction: 1 = write (hdout), 0 = read
- hd_addr  out  DATA_W  HD address
- hd_wdata  out  DATA_W  HD write data
- hd_rdata  in  DATA_W  HD read data, valid with hd_ack
- hd_ack  in  1  HD completion, single-cycle pulse
- stall  out  1  upstream must hold alu_op/result/saida/op_valid
- wb_valid  out  1  wb_data valid (1-cycle pulse)
- wb_data  out  DATA_W  writeback value
- hd_erro  out  1  sticky: HD timeout occurred

Behaviour:
- Opcodes:
  - 100000 LW
  - 100001 SW
  - 111100 HDIN (read)
  - 111101 HDOUT (write)
  - 111110 HDINS (read, same as HDIN)
  - all others PASS
- Reset (reset_n = 0 at posedge), all outputs to 0:
  - state = OCIOSO
  - stall, wb_valid, mem_we, hd_req, hd_erro = 0
  - wb_data, mem_addr, mem_wdata, hd_addr, hd_wdata = 0
  - timeout counter = 0
  - Reset mid-transaction aborts it; no wb_valid is produced.
- FSM states: OCIOSO, LE_MEM, ESPERA_HD.
- OCIOSO with op_valid:
  - PASS: next cycle wb_valid = 1, wb_data = result. Stay OCIOSO. 1-cycle latency, no stall.
  - SW: mem_addr = result[MEM_AW-1:0], mem_wdata = saida, mem_we = 1 for one cycle. No wb_valid, no stall.
  - LW: drive mem_addr (combinationally from result), go to LE_MEM. stall = 1 combinationally in the accept cycle.
  - HD*: register hd_addr = result, hd_wdata = saida, hd_we; hd_req = 1 from the next cycle; go to ESPERA_HD. stall = 1 combinationally in the accept cycle. Timeout counter cleared.
- LE_MEM:
  - wb_data = mem_rdata, wb_valid = 1 next edge; return to OCIOSO.
  - stall = 1 during LE_MEM, so LW latency is 2 cycles.
- ESPERA_HD:
  - stall = 1; counter increments each cycle.
  - hd_ack = 1: drop hd_req; if read, wb_data = hd_rdata and wb_valid = 1 next edge; HDOUT gives no wb_valid; return to OCIOSO.
  - Counter == HD_TIMEOUT without ack: drop hd_req, set hd_erro, wb_data = 0, wb_valid = 1 for reads, return to OCIOSO.
  - hd_ack in the same cycle as the timeout: ack wins, no error.
- Ignored inputs:
  - op_valid ignored while state != OCIOSO.
  - hd_ack ignored outside ESPERA_HD.
- stall deasserts in the cycle the FSM returns to OCIOSO, so a new op may be accepted that cycle.
- Back-to-back PASS/SW ops are accepted every cycle.
- hd_erro clears only on reset.

Decomposition:
- Shared package holds:
  - the 6-bit opcode constants (LW, SW, HDIN, HDOUT, HDINS)
  - the FSM state encoding
- These constants are also used by the ALU and the control unit.
- Single natural sub-module: hd_handshake (req/ack/timeout counter), instantiated once. The RAM interface stays inline.

Test Plan:
- PASS: op 000000, result = 0x0000_0007, op_valid 1 cycle -> next cycle wb_valid = 1, wb_data = 7, stall never 1.
- SW then LW:
  - SW result = 0x12, saida = 0xDEADBEEF -> mem_we pulse, mem_addr = 0x12, mem_wdata = 0xDEADBEEF.
  - LW result = 0x12 with RAM model -> stall high 2 cycles, wb_data = 0xDEADBEEF on cycle 2.
- HDIN with ack after 5 cycles, hd_rdata = 0xA5A5 -> hd_req high 5 cycles, hd_we = 0, stall high throughout, wb_data = 0xA5A5, hd_erro = 0.
- HDOUT with no ack, HD_TIMEOUT = 8 -> hd_req drops after 8 cycles, hd_erro = 1 and stays 1, no wb_valid; next PASS op completes normally.
- Reset abort: reset_n = 0 for 1 cycle while in ESPERA_HD -> next cycle hd_req = 0, stall = 0, hd_erro = 0, no wb_valid; a late hd_ack is ignored.
- Ack/timeout tie: hd_ack in the same cycle the counter hits HD_TIMEOUT on an HDIN -> wb_data = hd_rdata, hd_erro stays 0.

Source files
------------

// File: rtl/estagio_memoria_pkg.sv
// Shared opcode constants and memory-stage FSM encoding.
// Also imported by the ALU and the control unit.
package estagio_memoria_pkg;

    localparam logic [5:0] OP_LW    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b100001;
    localparam logic [5:0] OP_HDIN  = 6'b111100;
    localparam logic [5:0] OP_HDOUT = 6'b111101;
    localparam logic [5:0] OP_HDINS = 6'b111110;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        LE_MEM    = 2'd1,
        ESPERA_HD = 2'd2
    } estado_t;

    function automatic logic op_e_hd(input logic [5:0] op);
        return (op == OP_HDIN) || (op == OP_HDOUT) || (op == OP_HDINS);
    endfunction

endpackage

// File: rtl/estagio_memoria_if.sv
// Data-RAM and HD device bus seen by the memory stage.
// master = memory stage, slave = RAM/HD side.
interface estagio_memoria_if #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 10
);
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              hd_req;
    logic              hd_we;
    logic [DATA_W-1:0] hd_addr;
    logic [DATA_W-1:0] hd_wdata;
    logic [DATA_W-1:0] hd_rdata;
    logic              hd_ack;

    modport master (
        output mem_addr, mem_we, mem_wdata,
        output hd_req, hd_we, hd_addr, hd_wdata,
        input  mem_rdata, hd_rdata, hd_ack
    );

    modport slave (
        input  mem_addr, mem_we, mem_wdata,
        input  hd_req, hd_we, hd_addr, hd_wdata,
        output mem_rdata, hd_rdata, hd_ack
    );
endinterface

// File: rtl/estagio_memoria_hd_handshake.sv
// HD request/acknowledge handshake with a bounded wait.
// hd_req rises the cycle after inicia and stays up for at most HD_TIMEOUT cycles.
module estagio_memoria_hd_handshake #(
    parameter int DATA_W     = 32,
    parameter int HD_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inicia,
    input  logic              inicia_we,
    input  logic [DATA_W-1:0] inicia_addr,
    input  logic [DATA_W-1:0] inicia_wdata,
    input  logic              ack,
    output logic              hd_req,
    output logic              hd_we,
    output logic [DATA_W-1:0] hd_addr,
    output logic [DATA_W-1:0] hd_wdata,
    output logic              fim,
    output logic              estouro
);
    localparam int CNT_W = $clog2(HD_TIMEOUT + 1);
    // cnt holds the wait cycles already elapsed, so the current cycle is
    // number cnt+1; the bound trips on the HD_TIMEOUT-th cycle of hd_req.
    localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(HD_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;
    logic             limite;

    assign limite  = hd_req && (cnt == CNT_ULTIMO);
    assign fim     = hd_req && (ack || limite);
    // an ack arriving on the last allowed cycle still counts as success
    assign estouro = limite && !ack;

    // request register, captured transfer fields and wait counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hd_req   <= 1'b0;
            hd_we    <= 1'b0;
            hd_addr  <= '0;
            hd_wdata <= '0;
            cnt      <= '0;
        end else if (inicia) begin
            hd_req   <= 1'b1;
            hd_we    <= inicia_we;
            hd_addr  <= inicia_addr;
            hd_wdata <= inicia_wdata;
            cnt      <= '0;
        end else if (fim) begin
            hd_req   <= 1'b0;
        end else if (hd_req) begin
            cnt      <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/estagio_memoria.sv
// Memory/IO stage: data-RAM loads/stores, HD transfers, registered writeback.
//
//  state     | meaning
//  OCIOSO    | idle, accepts a new op every cycle
//  LE_MEM    | RAM read data arriving, written back at the next edge
//  ESPERA_HD | HD request outstanding, waiting for ack or timeout
module estagio_memoria
    import estagio_memoria_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MEM_AW     = 10,
    parameter int HD_TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 op_valid,
    input  logic [5:0]           alu_op,
    input  logic [DATA_W-1:0]    result,
    input  logic [DATA_W-1:0]    saida,
    estagio_memoria_if.master    bus,
    output logic                 stall,
    output logic                 wb_valid,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 hd_erro
);
    estado_t estado, estado_prox;

    logic              aceita;
    logic              op_lw, op_sw, op_hd, op_pass;
    logic              mem_acesso;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              hd_req, hd_we, hd_fim, hd_estouro;
    logic [DATA_W-1:0] hd_addr, hd_wdata;

    // reset gating keeps a held op from writing RAM during reset
    assign aceita  = reset_n && (estado == OCIOSO) && op_valid;
    assign op_lw   = (alu_op == OP_LW);
    assign op_sw   = (alu_op == OP_SW);
    assign op_hd   = op_e_hd(alu_op);
    assign op_pass = !op_lw && !op_sw && !op_hd;

    // RAM address and write strobe are combinational so a store and a
    // following load in the next cycle see the same RAM timing
    assign mem_acesso    = aceita && (op_lw || op_sw);
    assign bus.mem_addr  = mem_acesso ? result[MEM_AW-1:0] : mem_addr_q;
    assign bus.mem_wdata = (aceita && op_sw) ? saida : mem_wdata_q;
    assign bus.mem_we    = aceita && op_sw;

    estagio_memoria_hd_handshake #(
        .DATA_W     (DATA_W),
        .HD_TIMEOUT (HD_TIMEOUT)
    ) u_hd (
        .clock        (clock),
        .reset_n      (reset_n),
        .inicia       (aceita && op_hd),
        .inicia_we    (alu_op == OP_HDOUT),
        .inicia_addr  (result),
        .inicia_wdata (saida),
        .ack          (bus.hd_ack),
        .hd_req       (hd_req),
        .hd_we        (hd_we),
        .hd_addr      (hd_addr),
        .hd_wdata     (hd_wdata),
        .fim          (hd_fim),
        .estouro      (hd_estouro)
    );

    assign bus.hd_req   = hd_req;
    assign bus.hd_we    = hd_we;
    assign bus.hd_addr  = hd_addr;
    assign bus.hd_wdata = hd_wdata;

    // state register
    always_ff @(posedge clock) begin
        if (!reset_n) estado <= OCIOSO;
        else          estado <= estado_prox;
    end

    // next state and stall
    always_comb begin
        estado_prox = estado;
        stall       = 1'b0;
        case (estado)
            OCIOSO: begin
                if (aceita && op_lw) begin
                    estado_prox = LE_MEM;
                    stall       = 1'b1;
                end else if (aceita && op_hd) begin
                    estado_prox = ESPERA_HD;
                    stall       = 1'b1;
                end
            end
            LE_MEM: begin
                stall       = 1'b1;
                estado_prox = OCIOSO;
            end
            ESPERA_HD: begin
                stall = 1'b1;
                if (hd_fim) estado_prox = OCIOSO;
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // writeback, sticky HD error and held RAM address/data
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            hd_erro     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (mem_acesso) mem_addr_q <= result[MEM_AW-1:0];
            if (aceita && op_sw) mem_wdata_q <= saida;
            case (estado)
                OCIOSO: begin
                    if (aceita && op_pass) begin
                        wb_valid <= 1'b1;
                        wb_data  <= result;
                    end
                end
                LE_MEM: begin
                    wb_valid <= 1'b1;
                    wb_data  <= bus.mem_rdata;
                end
                ESPERA_HD: begin
                    if (hd_fim) begin
                        if (!hd_we) begin
                            wb_valid <= 1'b1;
                            wb_data  <= hd_estouro ? '0 : bus.hd_rdata;
                        end
                        if (hd_estouro) hd_erro <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_estagio_memoria.sv
// Directed bench for estagio_memoria with a small synchronous RAM model.
module tb_estagio_memoria;
    import estagio_memoria_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        op_valid;
    logic [5:0]  alu_op;
    logic [31:0] result, saida;
    logic        stall, wb_valid, hd_erro;
    logic [31:0] wb_data;
    logic        hd_ack;
    logic [31:0] hd_rdata;
    logic [31:0] ram [0:1023];
    logic [31:0] ram_q;

    int checks = 0;
    int errors = 0;

    estagio_memoria_if #(.DATA_W(32), .MEM_AW(10)) bus_i ();

    estagio_memoria #(.DATA_W(32), .MEM_AW(10), .HD_TIMEOUT(8)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .op_valid (op_valid),
        .alu_op   (alu_op),
        .result   (result),
        .saida    (saida),
        .bus      (bus_i),
        .stall    (stall),
        .wb_valid (wb_valid),
        .wb_data  (wb_data),
        .hd_erro  (hd_erro)
    );

    always #5 clock = ~clock;

    assign bus_i.mem_rdata = ram_q;
    assign bus_i.hd_ack    = hd_ack;
    assign bus_i.hd_rdata  = hd_rdata;

    always @(posedge clock) begin
        if (bus_i.mem_we) ram[bus_i.mem_addr] <= bus_i.mem_wdata;
        ram_q <= ram[bus_i.mem_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] r, input logic [31:0] s);
        op_valid = 1'b1;
        alu_op   = op;
        result   = r;
        saida    = s;
    endtask

    // n cycles of outstanding HD request; optional ack on the last one
    task automatic hd_wait(input string tag, input int n, input bit ack_last, input logic [31:0] dado);
        for (int k = 1; k <= n; k++) begin
            if (ack_last && k == n) begin
                hd_ack   = 1'b1;
                hd_rdata = dado;
            end
            #1;
            chk1({tag, "_req"}, bus_i.hd_req, 1'b1);
            chk1({tag, "_stall"}, stall, 1'b1);
            chk1({tag, "_nowb"}, wb_valid, 1'b0);
            tick();
            hd_ack = 1'b0;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        op_valid = 1'b0;
        alu_op   = 6'd0;
        result   = '0;
        saida    = '0;
        hd_ack   = 1'b0;
        hd_rdata = '0;
        tick();
        tick();

        chk1 ("rst_stall",     stall, 1'b0);
        chk1 ("rst_wb_valid",  wb_valid, 1'b0);
        chk32("rst_wb_data",   wb_data, 32'h0);
        chk1 ("rst_hd_req",    bus_i.hd_req, 1'b0);
        chk1 ("rst_hd_erro",   hd_erro, 1'b0);
        chk1 ("rst_mem_we",    bus_i.mem_we, 1'b0);
        chk32("rst_mem_addr",  32'(bus_i.mem_addr), 32'h0);
        chk32("rst_mem_wdata", bus_i.mem_wdata, 32'h0);
        chk32("rst_hd_addr",   bus_i.hd_addr, 32'h0);
        chk32("rst_hd_wdata",  bus_i.hd_wdata, 32'h0);
        reset_n = 1'b1;
        tick();

        // PASS, 1-cycle latency, no stall
        issue(6'b000000, 32'h0000_0007, 32'h0);
        #1;
        chk1("pass_stall", stall, 1'b0);
        tick();
        op_valid = 1'b0;
        chk1 ("pass_wb_valid", wb_valid, 1'b1);
        chk32("pass_wb_data",  wb_data, 32'h7);
        chk1 ("pass_stall2",   stall, 1'b0);
        tick();
        chk1 ("pass_wb_pulse", wb_valid, 1'b0);

        // back-to-back PASS
        issue(6'b000011, 32'h11, 32'h0);
        tick();
        issue(6'b101010, 32'h22, 32'h0);
        chk32("b2b_first", wb_data, 32'h11);
        #1;
        chk1 ("b2b_stall", stall, 1'b0);
        tick();
        op_valid = 1'b0;
        chk1 ("b2b_valid2", wb_valid, 1'b1);
        chk32("b2b_second", wb_data, 32'h22);
        tick();

        // SW
        issue(OP_SW, 32'h12, 32'hDEAD_BEEF);
        #1;
        chk1 ("sw_we",    bus_i.mem_we, 1'b1);
        chk32("sw_addr",  32'(bus_i.mem_addr), 32'h12);
        chk32("sw_wdata", bus_i.mem_wdata, 32'hDEAD_BEEF);
        chk1 ("sw_stall", stall, 1'b0);
        tick();
        op_valid = 1'b0;
        #1;
        chk1 ("sw_we_pulse", bus_i.mem_we, 1'b0);
        chk1 ("sw_no_wb",    wb_valid, 1'b0);

        // LW from the address just stored
        issue(OP_LW, 32'h12, 32'h0);
        #1;
        chk1 ("lw_stall1", stall, 1'b1);
        chk32("lw_addr",   32'(bus_i.mem_addr), 32'h12);
        tick();
        op_valid = 1'b0;
        #1;
        chk1 ("lw_stall2", stall, 1'b1);
        chk1 ("lw_nowb",   wb_valid, 1'b0);
        tick();
        chk1 ("lw_wb_valid", wb_valid, 1'b1);
        chk32("lw_wb_data",  wb_data, 32'hDEAD_BEEF);
        chk1 ("lw_stall_off", stall, 1'b0);

        // HDIN acked on the 5th request cycle
        issue(OP_HDIN, 32'h300, 32'h55);
        #1;
        chk1("hdin_stall0", stall, 1'b1);
        chk1("hdin_req0",   bus_i.hd_req, 1'b0);
        tick();
        op_valid = 1'b0;
        chk1 ("hdin_we",   bus_i.hd_we, 1'b0);
        chk32("hdin_addr", bus_i.hd_addr, 32'h300);
        hd_wait("hdin", 5, 1'b1, 32'h0000_A5A5);
        chk1 ("hdin_req_off", bus_i.hd_req, 1'b0);
        chk1 ("hdin_wb_valid", wb_valid, 1'b1);
        chk32("hdin_wb_data",  wb_data, 32'h0000_A5A5);
        chk1 ("hdin_erro",     hd_erro, 1'b0);
        chk1 ("hdin_stall_off", stall, 1'b0);

        // HDOUT timeout after 8 cycles
        issue(OP_HDOUT, 32'h40, 32'h99);
        tick();
        op_valid = 1'b0;
        chk1 ("hdout_we",    bus_i.hd_we, 1'b1);
        chk32("hdout_wdata", bus_i.hd_wdata, 32'h99);
        hd_wait("hdout", 8, 1'b0, 32'h0);
        chk1("hdout_req_off", bus_i.hd_req, 1'b0);
        chk1("hdout_erro",    hd_erro, 1'b1);
        chk1("hdout_no_wb",   wb_valid, 1'b0);
        chk1("hdout_stall",   stall, 1'b0);
        issue(6'b000001, 32'h5A, 32'h0);
        tick();
        op_valid = 1'b0;
        chk1 ("after_to_valid", wb_valid, 1'b1);
        chk32("after_to_data",  wb_data, 32'h5A);
        chk1 ("erro_sticky",    hd_erro, 1'b1);
        tick();

        // reset while waiting on HD
        issue(OP_HDINS, 32'h77, 32'h0);
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk1("rabort_req",   bus_i.hd_req, 1'b0);
        chk1("rabort_stall", stall, 1'b0);
        chk1("rabort_erro",  hd_erro, 1'b0);
        chk1("rabort_wb",    wb_valid, 1'b0);
        hd_ack   = 1'b1;
        hd_rdata = 32'h0000_0BAD;
        tick();
        hd_ack = 1'b0;
        chk1("late_ack_wb",    wb_valid, 1'b0);
        chk1("late_ack_stall", stall, 1'b0);
        chk1("late_ack_erro",  hd_erro, 1'b0);
        tick();
        chk1 ("late_ack_wb2",  wb_valid, 1'b0);
        chk32("late_ack_data", wb_data, 32'h0);

        // ack on the same cycle as the timeout bound
        issue(OP_HDIN, 32'h8, 32'h0);
        tick();
        op_valid = 1'b0;
        hd_wait("tie", 8, 1'b1, 32'h1234_5678);
        chk1 ("tie_wb_valid", wb_valid, 1'b1);
        chk32("tie_wb_data",  wb_data, 32'h1234_5678);
        chk1 ("tie_erro",     hd_erro, 1'b0);
        chk1 ("tie_req_off",  bus_i.hd_req, 1'b0);

        // read timeout writes back zero
        issue(OP_HDINS, 32'h9, 32'h0);
        tick();
        op_valid = 1'b0;
        hd_wait("rdto", 8, 1'b0, 32'h0);
        chk1 ("rdto_wb_valid", wb_valid, 1'b1);
        chk32("rdto_wb_data",  wb_data, 32'h0);
        chk1 ("rdto_erro",     hd_erro, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
